// File: rtl/regfile_dump_pkg.sv
// Shared types and helpers for the register file dump controller.
// Holds the controller state encoding and the modulo-N address increment.
package regfile_dump_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Wrap-around increment for register files whose depth is not a power of two.
  function automatic int unsigned next_addr(input int unsigned addr, input int unsigned n);
    return (addr == n - 1) ? 32'd0 : addr + 32'd1;
  endfunction

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Sweeps a wrap-around address range of a single-read-port register file and
// streams the words out on a valid/ready interface with a last marker.
module regfile_dump_ctrl
  import regfile_dump_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  localparam int AW   = $clog2(N)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [AW-1:0]    start_addr,
  input  logic [AW:0]      count,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             rf_read_en,
  output logic [AW-1:0]    rf_read_addr,
  input  logic [WIDTH-1:0] rf_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last
);

  localparam logic [AW:0] N_CNT = (AW+1)'(N);
  localparam logic [AW:0] ONE   = (AW+1)'(1);

  state_t           state_reg, state_next;
  logic [AW-1:0]    pointer_reg, pointer_next;
  logic [AW:0]      remaining_reg, remaining_next;
  logic             m_valid_reg, m_valid_next;
  logic             m_last_reg, m_last_next;
  logic [WIDTH-1:0] m_data_reg, m_data_next;
  logic             done_reg, done_next;
  logic             issue;
  logic [AW:0]      count_sat;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      pointer_reg   <= '0;
      remaining_reg <= '0;
      m_valid_reg   <= 1'b0;
      m_last_reg    <= 1'b0;
      m_data_reg    <= '0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pointer_reg   <= pointer_next;
      remaining_reg <= remaining_next;
      m_valid_reg   <= m_valid_next;
      m_last_reg    <= m_last_next;
      m_data_reg    <= m_data_next;
      done_reg      <= done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pointer_next   = pointer_reg;
    remaining_next = remaining_reg;
    m_valid_next   = m_valid_reg;
    m_last_next    = m_last_reg;
    m_data_next    = m_data_reg;
    done_next      = 1'b0;
    issue          = 1'b0;
    count_sat      = (count > N_CNT) ? N_CNT : count;

    case (state_reg)
      IDLE: begin
        // Start outranks a simultaneous abort here; a zero-length request only pulses done.
        if (start) begin
          pointer_next   = start_addr;
          remaining_next = count_sat;
          if (count_sat == '0) begin
            done_next = 1'b1;
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_next   = IDLE;
          m_valid_next = 1'b0;
          m_last_next  = 1'b0;
        end else begin
          issue = (!m_valid_reg || m_ready) && (remaining_reg != '0);
          if (issue) begin
            m_data_next    = rf_data;
            m_valid_next   = 1'b1;
            m_last_next    = (remaining_reg == ONE);
            remaining_next = remaining_reg - ONE;
            pointer_next   = AW'(next_addr(32'(pointer_reg), N));
            if (remaining_reg == ONE) begin
              state_next = FLUSH;
            end
          end else if (m_valid_reg && m_ready) begin
            m_valid_next = 1'b0;
          end
        end
      end
      FLUSH: begin
        if (abort) begin
          state_next   = IDLE;
          m_valid_next = 1'b0;
          m_last_next  = 1'b0;
        end else if (m_valid_reg && m_ready) begin
          state_next   = IDLE;
          m_valid_next = 1'b0;
          m_last_next  = 1'b0;
          done_next    = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy         = (state_reg != IDLE);
  assign done         = done_reg;
  assign rf_read_en   = issue;
  assign rf_read_addr = pointer_reg;
  assign m_valid      = m_valid_reg;
  assign m_data       = m_data_reg;
  assign m_last       = m_last_reg;

endmodule
